// File: rtl/rgb_uart_pkg.sv
// Shared definitions for the RGB-over-UART link: tx FSM encoding, frame shape, command byte fields.
package rgb_uart_pkg;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    // Command byte layout: bit 7 reserved (0), color[6:4], brightness[3:0]
    localparam int COLOR_MSB  = 6;
    localparam int COLOR_LSB  = 4;
    localparam int BRIGHT_MSB = 3;
    localparam int BRIGHT_LSB = 0;

    typedef struct packed {
        logic       rsvd;
        logic [2:0] color;
        logic [3:0] bright;
    } cmd_t;

    function automatic int frame_bits();
        return 1 + DATA_BITS + STOP_BITS;
    endfunction

    function automatic logic [7:0] make_cmd(input logic [2:0] color, input logic [3:0] bright);
        logic [7:0] b;
        b = '0;
        b[COLOR_MSB:COLOR_LSB]   = color;
        b[BRIGHT_MSB:BRIGHT_LSB] = bright;
        return b;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with wrap-bit pointers; read data is valid combinationally while !empty.
// Latency: one cycle write-to-read; push is dropped when full, pop is ignored when empty.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign pop_dat = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: entries are only read between matching push and pop.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first, fed from a small FIFO through valid/ready.
// Latency: accept at E0, start bit from E1; tx_ready = !full, frames back-to-back while data queued.
module uart_tx
    import rgb_uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       busy
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int IDX_W        = $clog2(DATA_BITS);

    tx_state_e              state_q, state_d;
    logic [CNT_W-1:0]       baud_cnt_q, baud_cnt_d;
    logic [IDX_W-1:0]       bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   tx_q, tx_d;
    logic                   busy_q, busy_d;

    logic                   fifo_pop;
    logic [DATA_BITS-1:0]   fifo_dat;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   cnt_last;

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (tx_valid),
        .push_dat (tx_data),
        .pop      (fifo_pop),
        .pop_dat  (fifo_dat),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign tx_ready = !fifo_full;
    assign tx       = tx_q;
    assign busy     = busy_q;
    assign cnt_last = (baud_cnt_q == CNT_W'(CLKS_PER_BIT - 1));

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        fifo_pop   = 1'b0;
        busy_d     = (state_q != TX_IDLE) || !fifo_empty;

        if (state_q != TX_IDLE) begin
            baud_cnt_d = cnt_last ? '0 : baud_cnt_q + CNT_W'(1);
        end

        // tx_d always carries the level of the bit period that begins at the next edge
        case (state_q)
            TX_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    shift_d    = fifo_dat;
                    baud_cnt_d = '0;
                    state_d    = TX_START;
                    tx_d       = 1'b0;
                end
            end
            TX_START: begin
                if (cnt_last) begin
                    state_d   = TX_DATA;
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
                end
            end
            TX_DATA: begin
                if (cnt_last) begin
                    shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
                    bit_idx_d = bit_idx_q + IDX_W'(1);
                    if (bit_idx_q == IDX_W'(DATA_BITS - 1)) begin
                        state_d = TX_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        tx_d    = shift_q[1];
                    end
                end
            end
            TX_STOP: begin
                if (cnt_last) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_dat;
                        state_d  = TX_START;
                        tx_d     = 1'b0;
                    end else begin
                        state_d  = TX_IDLE;
                        tx_d     = 1'b1;
                    end
                end
            end
            default: begin
                state_d = TX_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= TX_IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: timeline reference model of accepted bytes and their frame slots.
module tb_uart_tx;
    import rgb_uart_pkg::*;

    localparam int CLK_FREQ = 1_000_000;
    localparam int BAUD     = 100_000;
    localparam int DEPTH    = 4;
    localparam int CPB      = CLK_FREQ / BAUD;
    localparam int FRAME    = 10 * CPB;
    localparam int MAXB     = 256;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       tx;
    logic       busy;

    uart_tx #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx       (tx),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // cyc = number of rising edges seen so far
    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Reference model: each accepted byte occupies the slot
    // start = max(accept_edge + 1, previous_start + FRAME), frame = 0, d[0..7], 1.
    int         n_frm         = 0;
    int         acc_e   [MAXB];
    int         start_e [MAXB];
    logic [7:0] dat     [MAXB];
    int         last_start    = -1000000;
    int         last_acc_edge = -1;

    function automatic int occ_at(input int t);
        int o;
        o = 0;
        for (int k = 0; k < n_frm; k++) begin
            if (acc_e[k] <= t)   o++;
            if (start_e[k] <= t) o--;
        end
        return o;
    endfunction

    function automatic logic active_at(input int t);
        for (int k = 0; k < n_frm; k++) begin
            if (t >= start_e[k] && t < start_e[k] + FRAME) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic line_at(input int t);
        int         idx;
        logic [7:0] b;
        for (int k = 0; k < n_frm; k++) begin
            if (t >= start_e[k] && t < start_e[k] + FRAME) begin
                idx = (t - start_e[k]) / CPB;
                b   = dat[k];
                if (idx == 0) return 1'b0;
                if (idx > DATA_BITS) return 1'b1;
                return b[idx-1];
            end
        end
        return 1'b1;
    endfunction

    // Mid-cycle monitor: compares the line, ready and busy against the model,
    // then records an acceptance for the coming edge.
    initial begin
        int t;
        int occ;
        forever begin
            @(negedge clk);
            t = cyc;
            if (!rst_n) begin
                n_frm      = 0;
                last_start = -1000000;
                check_eq("rst_tx",    32'(tx),       32'd1);
                check_eq("rst_ready", 32'(tx_ready), 32'd1);
                check_eq("rst_busy",  32'(busy),     32'd0);
            end else begin
                occ = occ_at(t);
                check_eq("tx_line",  32'(tx),       32'(line_at(t)));
                check_eq("tx_ready", 32'(tx_ready), 32'(occ < DEPTH));
                check_eq("busy",     32'(busy),     32'(active_at(t - 1) || (occ_at(t - 1) > 0)));
                if (tx_valid && occ < DEPTH && n_frm < MAXB) begin
                    acc_e[n_frm]   = t + 1;
                    dat[n_frm]     = tx_data;
                    start_e[n_frm] = (t + 2 > last_start + FRAME) ? t + 2 : last_start + FRAME;
                    last_start     = start_e[n_frm];
                    last_acc_edge  = t + 1;
                    n_frm++;
                end
            end
        end
    end

    // All driver tasks start and end at posedge + 1.
    task automatic wait_cycles(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        int budget;
        logic ok;
        budget   = 0;
        ok       = 1'b0;
        tx_valid = 1'b1;
        tx_data  = d;
        while (!ok && budget < 2000) begin
            @(posedge clk);
            #1;
            budget++;
            if (last_acc_edge == cyc) ok = 1'b1;
        end
        check_eq("send_accept", 32'(ok), 32'd1);
    endtask

    task automatic drain();
        tx_valid = 1'b0;
        while (cyc < last_start + FRAME + 5) begin
            @(posedge clk);
            #1;
        end
        check_eq("drain_busy", 32'(busy), 32'd0);
        check_eq("drain_tx",   32'(tx),   32'd1);
    endtask

    task automatic wait_neg(input int target);
        @(negedge clk);
        while (cyc < target) @(negedge clk);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int         e1;
        int         gap;
        logic [9:0] pat;

        // Reset and idle line
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_cycles(100);
        check_eq("idle_tx",    32'(tx),       32'd1);
        check_eq("idle_ready", 32'(tx_ready), 32'd1);

        // Single byte 0x35: line reads 0, 1,0,1,0,1,1,0,0, 1 mid-bit
        send(make_cmd(3'd3, 4'd5));
        tx_valid = 1'b0;
        e1  = last_acc_edge + 1;
        pat = 10'b1001101010;
        wait_neg(e1 - 1);
        check_eq("pre_start_tx", 32'(tx), 32'd1);
        wait_neg(e1);
        check_eq("start_edge_tx", 32'(tx), 32'd0);
        for (int k = 0; k < 10; k++) begin
            wait_neg(e1 + k * CPB + CPB / 2);
            check_eq("midbit", 32'(tx), 32'(pat[k]));
        end
        wait_neg(e1 + FRAME - 1);
        check_eq("stop_last_tx", 32'(tx), 32'd1);
        wait_neg(e1 + FRAME);
        check_eq("busy_hold", 32'(busy), 32'd1);
        wait_neg(e1 + FRAME + 1);
        check_eq("busy_drop", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        drain();

        // FIFO fill: 6 bytes with valid held
        for (int i = 1; i <= 6; i++) begin
            send(8'(i));
            if (i == 5) check_eq("fill_ready_low", 32'(tx_ready), 32'd0);
        end
        drain();

        // Backpressure: 0xFF held while full must never be written
        for (int i = 0; i < 5; i++) send(8'h10 + 8'(i));
        tx_data = 8'hFF;
        for (int i = 0; i < 50; i++) begin
            wait_cycles(1);
            if (i % 10 == 0) check_eq("bp_ready_low", 32'(tx_ready), 32'd0);
        end
        send(8'h7A);
        drain();

        // Push exactly on the final STOP cycle with one entry queued
        send(8'hA5);
        e1 = last_acc_edge + 1;
        send(8'h3C);
        tx_valid = 1'b0;
        while (cyc < e1 + FRAME - 1) begin
            @(posedge clk);
            #1;
        end
        send(8'hC3);
        tx_valid = 1'b0;
        check_eq("pushpop_edge",  32'(last_acc_edge), 32'(e1 + FRAME));
        check_eq("pushpop_ready", 32'(tx_ready),      32'd1);
        drain();

        // Reset during data bit 3 of 0x00
        send(8'h00);
        tx_valid = 1'b0;
        e1 = last_acc_edge + 1;
        while (cyc < e1 + 4 * CPB + 4) begin
            @(posedge clk);
            #1;
        end
        check_eq("pre_rst_tx", 32'(tx), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_tx",    32'(tx),       32'd1);
        check_eq("mid_rst_busy",  32'(busy),     32'd0);
        check_eq("mid_rst_ready", 32'(tx_ready), 32'd1);
        wait_cycles(3);
        rst_n = 1'b1;
        wait_cycles(2);
        send(8'h5A);
        drain();

        // Random bytes with random gaps and bursts
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                gap = int'($urandom_range(0, 120));
                tx_valid = 1'b0;
                wait_cycles(gap);
            end
            send(8'($urandom));
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter for the RGB-over-UART design: the transmit end of the 8N1 serial link whose receive end delivers `command` bytes to the LED PWM controller. Bytes presented on a valid/ready interface are buffered in a small FIFO and serialized LSB-first on `tx`. It is used to echo or send command bytes, where each byte is bit 7 = 0, color[6:4], brightness[3:0]. The transmitter does not interpret byte contents.

## Interface
- `CLK_FREQ`, default 50_000_000: clock frequency in Hz.
- `BAUD`, default 115200: line rate. `CLKS_PER_BIT = CLK_FREQ/BAUD` uses integer division, and the result must be ≥ 2.
- `FIFO_DEPTH`, default 4: buffer entries. Must be a power of 2 and ≥ 2.
- `clk` input, 1 bit: the single clock.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `tx_data` input, 8 bits: byte to send.
- `tx_valid` input, 1 bit: `tx_data` is valid.
- `tx_ready` output, 1 bit: the FIFO can accept a byte. Equals `!full`.
- `tx` output, 1 bit: serial line. Idle level is high.
- `busy` output, 1 bit: high when the FSM is not in IDLE or the FIFO is non-empty.

## Operation
- Reset values: `tx` = 1, `tx_ready` = 1, `busy` = 0, FIFO empty, FSM in IDLE, all counters 0.
- Handshake: a byte is accepted at a rising edge where `tx_valid && tx_ready`.
  - When `tx_ready` = 0, `tx_valid` is ignored and nothing is written.
  - The source may change `tx_data` freely after acceptance.
- FIFO: the write pointer and read pointer are each log2(FIFO_DEPTH)+1 bits wide. The extra bit is a wrap bit.
  - Empty when the pointers are equal.
  - Full when the low bits are equal and the wrap bits differ.
- A push and a pop in the same cycle are both performed, and the occupancy is unchanged.
- FSM states and transitions:
  - IDLE: `tx` = 1. If the FIFO is non-empty, pop into the shift register, clear the baud counter, and go to START.
  - START: `tx` = 0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: `tx` = shift[0] for CLKS_PER_BIT cycles per bit, LSB first. After each bit, shift right and increment the bit index. After bit 7, go to STOP.
  - STOP: `tx` = 1 for CLKS_PER_BIT cycles. On the final cycle:
    - If the FIFO is non-empty, pop and go directly to START, with no idle gap.
    - Otherwise go to IDLE.
- The baud counter counts 0..CLKS_PER_BIT-1 and wraps. It advances only outside IDLE.
- `tx` is driven from a register, so it is glitch-free.
- Reset mid-frame: `tx` returns high immediately and asynchronously. The partial frame is lost, the FIFO contents are discarded, and no trailing stop bit is sent.

## Timing
- A byte accepted at edge E0 into an empty FIFO with the FSM in IDLE:
  - The pop happens at E1, and `tx` falls after E1.
  - The start bit occupies E1..E1+CLKS_PER_BIT.
  - Data bit k begins at E1+(k+1)·CLKS_PER_BIT.
  - The stop bit ends at E1+10·CLKS_PER_BIT.
- Frame length is exactly 10·CLKS_PER_BIT cycles. Back-to-back frames are continuous.
- `tx_ready` falls in the cycle after the write that fills the FIFO. It rises in the cycle after the next pop.
- `busy` goes high the cycle after the first acceptance. It goes low the cycle after the STOP→IDLE transition with the FIFO empty.
- Sustained throughput is 1 byte per 10·CLKS_PER_BIT cycles. The FIFO absorbs bursts of up to FIFO_DEPTH bytes while a frame is in flight, i.e. FIFO_DEPTH+1 bytes in total.

## Structure
- Shared package `rgb_uart_pkg`:
  - Tx FSM state encoding (IDLE, START, DATA, STOP).
  - Frame constants: 8 data bits, 1 stop bit.
  - Command field positions: COLOR_MSB = 6, COLOR_LSB = 4, BRIGHT_MSB = 3, BRIGHT_LSB = 0. The receive-side PWM controller uses the same constants.
- One sub-module, `uart_tx_fifo`: a synchronous FIFO parameterized by width and depth, with push/pop/full/empty. The FSM and baud counter stay in `uart_tx`.

## Test plan
All scenarios use CLK_FREQ = 1_000_000, BAUD = 100_000, so CLKS_PER_BIT = 10.
- **Reset state:** assert `rst_n` low for 3 cycles → `tx` = 1, `tx_ready` = 1, `busy` = 0. `tx` stays high for 100 cycles with no input.
- **Single byte:** send 0x35 (color 3, brightness 5) at E0.
  - `tx` falls at E1.
  - Sampled mid-bit, the line reads 0, 1,0,1,0,1,1,0,0, 1.
  - The frame lasts exactly 100 cycles.
  - `busy` drops at E1+101.
- **FIFO fill:** send 6 bytes 0x01..0x06 with `tx_valid` held high.
  - 5 bytes are accepted immediately: one goes to the shifter and 4 to the FIFO.
  - `tx_ready` is low until the first FIFO pop.
  - All 6 frames appear back-to-back with no gap, in order, spanning 600 cycles.
- **Backpressure:** with the FIFO full, hold `tx_valid` = 1 with `tx_data` = 0xFF for 50 cycles, then change to 0x7A → 0xFF is not written during `!tx_ready` and only 0x7A is accepted once ready.
- **Simultaneous push/pop:** push exactly in the STOP final cycle with 1 entry queued → occupancy is unchanged, the next START begins the following cycle, and no data is lost or duplicated.
- **Reset mid-frame:** assert `rst_n` during data bit 3 of 0x00 → `tx` goes high within the same cycle and `busy` = 0. A fresh byte 0x5A sent after release transmits correctly.
